dcache_ctrl: RTL and testbench

- Data-cache controller sitting in the MEM stage.
- It is the producer of the memory-stall signal that every pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC consume as stall_i.
- Direct-mapped, write-back, write-allocate cache of 32 lines × 256-bit blocks.
- Talks to off-chip data memory through a request/ack handshake and holds the pipeline frozen until each access completes.

---
 rtl/dcache_pkg.sv | 38 +++
 rtl/dcache_sram.sv | 54 +++++
 rtl/dcache_ctrl.sv | 125 ++++++++++++
 tb/tb_dcache_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared widths, FSM encoding and address helpers for the data-cache controller.
package dcache_pkg;

  localparam int LINES    = 32;
  localparam int INDEX_W  = 5;
  localparam int OFFSET_W = 5;
  localparam int TAG_W    = 22;
  localparam int BLOCK_W  = 256;
  localparam int WORD_W   = 32;
  localparam int WSEL_W   = 3;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_MISS       = 3'd1,
    ST_WRITEBACK  = 3'd2,
    ST_READMISS   = 3'd3,
    ST_READMISSOK = 3'd4
  } state_t;

  // CPU byte address split into cache fields; byte_off is always zero for word accesses.
  typedef struct packed {
    logic [TAG_W-1:0]   tag;
    logic [INDEX_W-1:0] index;
    logic [WSEL_W-1:0]  word;
    logic [1:0]         byte_off;
  } addr_fields_t;

  function automatic addr_fields_t split_addr(input logic [31:0] addr);
    return addr_fields_t'(addr);
  endfunction

  // Block-aligned memory address for a given tag/index pair.
  function automatic logic [31:0] line_addr(input logic [TAG_W-1:0]   tag,
                                            input logic [INDEX_W-1:0] index);
    return {tag, index, {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage for the direct-mapped cache.
// Reads are asynchronous; writes are either a whole-block refill or a single word.
module dcache_sram
  import dcache_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [INDEX_W-1:0] idx_i,
  output logic [TAG_W-1:0]   tag_o,
  output logic               valid_o,
  output logic               dirty_o,
  output logic [BLOCK_W-1:0] data_o,
  input  logic               blk_we_i,
  input  logic [TAG_W-1:0]   blk_tag_i,
  input  logic [BLOCK_W-1:0] blk_data_i,
  input  logic               word_we_i,
  input  logic [WSEL_W-1:0]  word_sel_i,
  input  logic [WORD_W-1:0]  word_data_i
);

  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [BLOCK_W-1:0] data_q [LINES];
  logic [LINES-1:0]   valid_q;
  logic [LINES-1:0]   dirty_q;

  assign tag_o   = tag_q[idx_i];
  assign data_o  = data_q[idx_i];
  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];

  // Line status: a refill installs a clean line, a store hit marks it dirty.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (blk_we_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= 1'b0;
    end else if (word_we_i) begin
      dirty_q[idx_i] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; valid bits gate their contents.
  always_ff @(posedge clk_i) begin
    if (blk_we_i) begin
      tag_q[idx_i]  <= blk_tag_i;
      data_q[idx_i] <= blk_data_i;
    end else if (word_we_i) begin
      data_q[idx_i][{word_sel_i, 5'b0} +: WORD_W] <= word_data_i;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// MEM-stage data-cache controller: direct-mapped, write-back, write-allocate.
// Produces the pipeline-wide stall and runs the write-back / refill handshake.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   IDLE       | serving hits; a miss moves to MISS
//   MISS       | one decision cycle: victim dirty -> WRITEBACK, else READMISS
//   WRITEBACK  | victim block sent to memory, waiting for ack
//   READMISS   | refill read outstanding; ack installs the block
//   READMISSOK | refilled line visible, request now hits; back to IDLE
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [31:0]        p1_addr_i,
  input  logic [31:0]        p1_data_i,
  input  logic               p1_MemRead_i,
  input  logic               p1_MemWrite_i,
  output logic [31:0]        p1_data_o,
  output logic               p1_stall_o,
  input  logic [BLOCK_W-1:0] mem_data_i,
  input  logic               mem_ack_i,
  output logic [BLOCK_W-1:0] mem_data_o,
  output logic [31:0]        mem_addr_o,
  output logic               mem_enable_o,
  output logic               mem_write_o
);

  state_t             state_q, state_d;
  addr_fields_t       cpu_f;
  logic [TAG_W-1:0]   line_tag;
  logic               line_valid;
  logic               line_dirty;
  logic [BLOCK_W-1:0] line_data;
  logic               req;
  logic               hit;
  logic               blk_we;
  logic               word_we;
  logic               unused_byte_off;

  assign cpu_f           = split_addr(p1_addr_i);
  assign unused_byte_off = ^cpu_f.byte_off;

  dcache_sram u_sram (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .idx_i       (cpu_f.index),
    .tag_o       (line_tag),
    .valid_o     (line_valid),
    .dirty_o     (line_dirty),
    .data_o      (line_data),
    .blk_we_i    (blk_we),
    .blk_tag_i   (cpu_f.tag),
    .blk_data_i  (mem_data_i),
    .word_we_i   (word_we),
    .word_sel_i  (cpu_f.word),
    .word_data_i (p1_data_i)
  );

  assign req        = p1_MemRead_i | p1_MemWrite_i;
  assign hit        = line_valid & (line_tag == cpu_f.tag);
  assign p1_stall_o = req & ~hit;

  // A pending store merges on the hit that follows the refill, so no state gating.
  assign word_we   = p1_MemWrite_i & hit;
  assign p1_data_o = (p1_MemRead_i & hit) ? line_data[{cpu_f.word, 5'b0} +: WORD_W] : '0;

  // State register; reset aborts any outstanding memory request.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and memory-port outputs; outputs depend on state only, so they stay stable until ack.
  always_comb begin
    state_d      = state_q;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    blk_we       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req && !hit) begin
          state_d = ST_MISS;
        end
      end
      ST_MISS: begin
        if (line_valid && line_dirty) begin
          state_d = ST_WRITEBACK;
        end else begin
          state_d = ST_READMISS;
        end
      end
      ST_WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = line_addr(line_tag, cpu_f.index);
        mem_data_o   = line_data;
        if (mem_ack_i) begin
          state_d = ST_READMISS;
        end
      end
      ST_READMISS: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = line_addr(cpu_f.tag, cpu_f.index);
        if (mem_ack_i) begin
          blk_we  = 1'b1;
          state_d = ST_READMISSOK;
        end
      end
      ST_READMISSOK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: the driver predicts each CPU completion and
// each memory transaction from a flat word-memory model plus a per-index tag view;
// independent monitor processes pop and compare when the DUT presents them.
module tb_dcache_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic [31:0]  p1_addr_i = '0;
  logic [31:0]  p1_data_i = '0;
  logic         p1_MemRead_i = 1'b0;
  logic         p1_MemWrite_i = 1'b0;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;
  logic [255:0] mem_data_i = '0;
  logic         mem_ack_i = 1'b0;
  logic [255:0] mem_data_o;
  logic [31:0]  mem_addr_o;
  logic         mem_enable_o;
  logic         mem_write_o;

  dcache_ctrl dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .p1_addr_i     (p1_addr_i),
    .p1_data_i     (p1_data_i),
    .p1_MemRead_i  (p1_MemRead_i),
    .p1_MemWrite_i (p1_MemWrite_i),
    .p1_data_o     (p1_data_o),
    .p1_stall_o    (p1_stall_o),
    .mem_data_i    (mem_data_i),
    .mem_ack_i     (mem_ack_i),
    .mem_data_o    (mem_data_o),
    .mem_addr_o    (mem_addr_o),
    .mem_enable_o  (mem_enable_o),
    .mem_write_o   (mem_write_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          stall;
  } cpu_exp_t;

  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } mem_exp_t;

  cpu_exp_t cpu_q[$];
  mem_exp_t mem_q[$];
  int       lat_q[$];

  logic [31:0]  flat [bit [31:0]];
  logic [255:0] phys [bit [31:0]];
  bit           ref_valid [32];
  logic [21:0]  ref_tag   [32];
  bit           ref_dirty [32];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h0000_0404) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (flat.exists(a)) return flat[a];
    return init_word(a);
  endfunction

  function automatic logic [255:0] model_line(input logic [31:0] base);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = model_rd(base + 32'(k * 4));
    return l;
  endfunction

  function automatic logic [255:0] phys_line(input logic [31:0] base);
    logic [255:0] l;
    if (phys.exists(base)) return phys[base];
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = init_word(base + 32'(k * 4));
    return l;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic finish_sim();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  // Memory responder: acks on the L-th enabled cycle and compares each transaction.
  initial begin : responder
    int cnt;
    int lat;
    mem_exp_t m;
    cnt = 0;
    lat = 1;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        mem_ack_i = 1'b0;
        cnt = 0;
      end else begin
        if (mem_ack_i) begin
          mem_ack_i = 1'b0;
          cnt = 0;
        end
        if (mem_enable_o) begin
          if (cnt == 0) lat = (lat_q.size() > 0) ? lat_q.pop_front() : 1;
          cnt++;
          if (cnt >= lat) begin
            if (mem_q.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL mem_unexpected: got request addr %0h write %0b, expected none", mem_addr_o, mem_write_o);
            end else begin
              m = mem_q.pop_front();
              check("mem_write", 256'(mem_write_o), 256'(m.wr));
              check("mem_addr", 256'(mem_addr_o), 256'(m.addr));
              if (m.wr) check("mem_wb_data", mem_data_o, m.data);
            end
            if (mem_write_o) phys[mem_addr_o] = mem_data_o;
            else mem_data_i = phys_line(mem_addr_o);
            mem_ack_i = 1'b1;
          end
        end
      end
    end
  end

  // CPU-side monitor: counts stalled cycles, compares on each completed access.
  initial begin : cpu_mon
    int stall_cnt;
    cpu_exp_t e;
    stall_cnt = 0;
    forever begin
      @(negedge clk_i);
      if (!rst_i || !(p1_MemRead_i || p1_MemWrite_i)) begin
        stall_cnt = 0;
      end else if (p1_stall_o) begin
        stall_cnt++;
      end else begin
        if (cpu_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL cpu_unexpected: got completion at addr %0h, expected none", p1_addr_i);
        end else begin
          e = cpu_q.pop_front();
          check("cpu_addr", 256'(p1_addr_i), 256'(e.addr));
          check("load_data", 256'(p1_data_o), 256'(e.data));
          check("stall_cycles", 256'(stall_cnt), 256'(e.stall));
        end
        stall_cnt = 0;
      end
    end
  end

  // One CPU access: predict, drive, wait for completion, release.
  task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input int lwb, input int lrf);
    int idx;
    logic [21:0] tg;
    cpu_exp_t e;
    mem_exp_t m;
    int k;
    idx = int'(a[9:5]);
    tg = a[31:10];
    e.addr = a;
    e.data = rd ? model_rd(a) : 32'h0;
    if (ref_valid[idx] && ref_tag[idx] == tg) begin
      e.stall = 0;
    end else begin
      e.stall = 2 + lrf;
      if (ref_valid[idx] && ref_dirty[idx]) begin
        e.stall += lwb;
        m.wr = 1'b1;
        m.addr = {ref_tag[idx], a[9:5], 5'b0};
        m.data = model_line(m.addr);
        mem_q.push_back(m);
        lat_q.push_back(lwb);
      end
      m.wr = 1'b0;
      m.addr = {tg, a[9:5], 5'b0};
      m.data = '0;
      mem_q.push_back(m);
      lat_q.push_back(lrf);
      ref_valid[idx] = 1'b1;
      ref_tag[idx] = tg;
      ref_dirty[idx] = 1'b0;
    end
    if (wr) begin
      flat[a] = d;
      ref_dirty[idx] = 1'b1;
    end
    cpu_q.push_back(e);
    p1_addr_i = a;
    p1_data_i = d;
    p1_MemRead_i = rd;
    p1_MemWrite_i = wr;
    for (k = 0; k < 300; k++) begin
      @(negedge clk_i);
      if (!p1_stall_o) break;
    end
    if (k == 300) begin
      n_cmp++;
      n_bad++;
      $display("FAIL access_timeout: got stall still high at addr %0h, expected release within 300 cycles", a);
      finish_sim();
    end
    @(posedge clk_i);
    #1;
    p1_MemRead_i = 1'b0;
    p1_MemWrite_i = 1'b0;
  endtask

  initial begin : watchdog
    #1_000_000;
    n_cmp++;
    n_bad++;
    $display("FAIL watchdog: got no completion, expected end of test");
    finish_sim();
  end

  initial begin : stim
    int k;
    logic [31:0] a;
    int op;

    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_stall_noreq", 256'(p1_stall_o), 256'(0));
    check("rst_p1_data", 256'(p1_data_o), 256'(0));
    check("rst_mem_enable", 256'(mem_enable_o), 256'(0));
    check("rst_mem_write", 256'(mem_write_o), 256'(0));
    check("rst_mem_addr", 256'(mem_addr_o), 256'(0));
    check("rst_mem_data", mem_data_o, 256'(0));
    p1_addr_i = 32'h0000_0404;
    p1_MemRead_i = 1'b1;
    #1;
    check("rst_stall_req", 256'(p1_stall_o), 256'(1));
    check("rst_p1_data_req", 256'(p1_data_o), 256'(0));
    p1_MemRead_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;

    // Directed sequence
    access(1, 0, 32'h0000_0404, 32'h0, 1, 10);
    access(1, 0, 32'h0000_0408, 32'h0, 1, 1);
    access(0, 1, 32'h0000_0404, 32'h1234_5678, 1, 1);
    access(1, 0, 32'h0000_0404, 32'h0, 1, 1);
    access(1, 0, 32'h0000_0C04, 32'h0, 4, 3);

    // Reset during an outstanding refill
    p1_addr_i = 32'h0000_1404;
    p1_MemRead_i = 1'b1;
    lat_q.push_back(40);
    for (k = 0; k < 20; k++) begin
      @(negedge clk_i);
      if (mem_enable_o) break;
    end
    check("abort_refill_started", 256'(mem_enable_o), 256'(1));
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    check("abort_mem_enable", 256'(mem_enable_o), 256'(0));
    check("abort_mem_addr", 256'(mem_addr_o), 256'(0));
    p1_MemRead_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    lat_q.delete();
    for (int i = 0; i < 32; i++) begin
      ref_valid[i] = 1'b0;
      ref_dirty[i] = 1'b0;
    end
    access(1, 0, 32'h0000_0C04, 32'h0, 1, 3);

    // Store miss allocates, then hits
    access(0, 1, 32'h0000_1010, 32'hCAFE_F00D, 1, 5);
    access(1, 0, 32'h0000_1010, 32'h0, 1, 1);
    access(1, 1, 32'h0000_1010, 32'h0BAD_CAFE, 1, 1);
    access(1, 0, 32'h0000_1010, 32'h0, 1, 1);

    // Randomized mix over a small set of conflicting lines
    for (int n = 0; n < 300; n++) begin
      a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 5) |
          (32'($urandom_range(0, 7)) << 2);
      op = int'($urandom_range(0, 2));
      access(op != 1, op != 0, a, $urandom, int'($urandom_range(1, 6)), int'($urandom_range(1, 6)));
      repeat ($urandom_range(0, 2)) @(posedge clk_i);
      #1;
    end

    repeat (5) @(posedge clk_i);
    #1;
    check("cpu_queue_drained", 256'(cpu_q.size()), 256'(0));
    check("mem_queue_drained", 256'(mem_q.size()), 256'(0));
    check("idle_mem_enable", 256'(mem_enable_o), 256'(0));
    finish_sim();
  end

endmodule
